sbus_mem_ctl: RTL and testbench

Behavioural SBUS memory controller: the storage stage directly downstream of the MBOX.
- Accepts MBOX quadword read and write requests over the SBUS.
- Acknowledges each accepted request, then returns or accepts up to four 36-bit words, one per requested RQ bit.
- Lets the MBOX cache-fill, writeback and uncached paths run in simulation and FPGA builds without a real MA20/MB20.

---
 rtl/sbus_pkg.sv | 30 +++
 rtl/sbus_mem_array.sv | 37 +++
 rtl/sbus_mem_ctl.sv | 168 ++++++++++++++++
 tb/tb_sbus_mem_ctl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// Shared types and the quadword word-order helper for the SBUS memory controller.
package sbus_pkg;

  typedef logic [35:0] word_t;
  typedef logic [21:0] pAdr_t;

  typedef enum logic [2:0] {IDLE, ACKWAIT, ACCESS, RDXFER, WRXFER} sbusState_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } next_t;

  // First index at or after cur (ascending, mod 4) that is requested and not yet visited.
  function automatic next_t nextWord(input logic [1:0] cur, input logic [3:0] rq,
                                     input logic [3:0] visited);
    next_t      r;
    logic [1:0] i;
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      i = cur + 2'(k);
      if (rq[i] && !visited[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sbus_mem_array.sv
// Single-port synchronous word RAM, write-first, one-cycle read latency.
module sbus_mem_array
  import sbus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [MEM_WORDS];
  word_t rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = we ? wdata : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register is cleared; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sbus_mem_ctl.sv
// Behavioural SBUS memory controller: accepts MBOX quadword reads/writes, acks them,
// then streams up to four words in wrapped request order.
module sbus_mem_ctl
  import sbus_pkg::*;
#(
  parameter int MEM_WORDS  = 4096,
  parameter int ACK_DLY    = 2,
  parameter int ACCESS_LAT = 3,
  parameter int WR_TIMEOUT = 16
) (
  input  logic        mboxClk,
  input  logic        CROBAR,
  input  logic        START,
  input  pAdr_t       ADR,
  input  logic [3:0]  RQ,
  input  logic        RD_RQ,
  input  logic        WR_RQ,
  input  word_t       DATA_IN,
  input  logic        DATA_IN_VALID,
  output logic        ACKN,
  output logic        DATA_VALID,
  output word_t       DATA_OUT,
  output logic [1:0]  WORD_NUM,
  output logic        BUSY,
  output logic        ERR
);

  localparam int AW = $clog2(MEM_WORDS);

  sbusState_t    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-3:0] base_q, base_d;
  logic [3:0]    rq_q, rq_d, vis_q, vis_d;
  logic          wr_q, wr_d, dv_q, dv_d, err_q, err_d;
  logic [1:0]    cur_q, cur_d, wn_q, wn_d;

  next_t         nxt, first_w;
  logic          rd_issue, mem_we, mem_re;
  logic [AW-1:0] mem_addr;

  assign ACKN       = (state_q == ACKWAIT) && (cnt_q == 16'(ACK_DLY));
  // Busy spans the last read word's DATA_VALID cycle even though the FSM is already idle.
  assign BUSY       = (state_q != IDLE) || dv_q;
  assign DATA_VALID = dv_q;
  assign WORD_NUM   = wn_q;
  assign ERR        = err_q;
  assign mem_addr   = {base_q, cur_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    rq_d     = rq_q;
    wr_d     = wr_q;
    cur_d    = cur_q;
    vis_d    = vis_q;
    wn_d     = wn_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    rd_issue = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    nxt      = nextWord(cur_q, rq_q, vis_q | (4'b0001 << cur_q));
    first_w  = nextWord(ADR[1:0], RQ, 4'b0000);

    case (state_q)
      IDLE: begin
        if (START && !dv_q) begin
          if ((RD_RQ == WR_RQ) || ({10'd0, ADR} >= MEM_WORDS)) begin
            err_d = 1'b1;
          end else begin
            state_d = ACKWAIT;
            cnt_d   = 16'd1;
            base_d  = ADR[AW-1:2];
            rq_d    = RQ;
            wr_d    = WR_RQ;
            cur_d   = first_w.idx;
            vis_d   = 4'b0000;
          end
        end
      end
      ACKWAIT: begin
        if (ACKN) begin
          if (rq_q == 4'b0000)    state_d = IDLE;
          else if (wr_q) begin
            state_d = WRXFER;
            cnt_d   = 16'd0;
          end
          else if (ACCESS_LAT == 1) rd_issue = 1'b1;
          else if (ACCESS_LAT == 2) state_d = RDXFER;
          else begin
            state_d = ACCESS;
            cnt_d   = 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACCESS: begin
        if (cnt_q >= 16'(ACCESS_LAT - 2)) state_d = RDXFER;
        else                              cnt_d   = cnt_q + 16'd1;
      end
      RDXFER: rd_issue = 1'b1;
      WRXFER: begin
        if (DATA_IN_VALID) begin
          mem_we = 1'b1;
          vis_d  = vis_q | (4'b0001 << cur_q);
          cur_d  = nxt.idx;
          cnt_d  = 16'd0;
          if (!nxt.found) state_d = IDLE;
        end else if (cnt_q + 16'd1 >= 16'(WR_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Array read goes out one cycle ahead of the matching DATA_VALID.
    if (rd_issue) begin
      mem_re  = 1'b1;
      dv_d    = 1'b1;
      wn_d    = cur_q;
      vis_d   = vis_q | (4'b0001 << cur_q);
      cur_d   = nxt.idx;
      state_d = nxt.found ? RDXFER : IDLE;
    end
  end

  always_ff @(posedge mboxClk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      rq_q    <= '0;
      wr_q    <= 1'b0;
      cur_q   <= '0;
      vis_q   <= '0;
      wn_q    <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      rq_q    <= rq_d;
      wr_q    <= wr_d;
      cur_q   <= cur_d;
      vis_q   <= vis_d;
      wn_q    <= wn_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  sbus_mem_array #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (mboxClk),
    .rst   (CROBAR),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (DATA_IN),
    .rdata (DATA_OUT)
  );

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// Directed bench for sbus_mem_ctl: table of read transactions plus hand-built corner sequences.
module tb_sbus_mem_ctl;
  import sbus_pkg::*;

  logic       clk = 1'b0;
  logic       CROBAR, START, RD_RQ, WR_RQ, DATA_IN_VALID;
  pAdr_t      ADR;
  logic [3:0] RQ;
  word_t      DATA_IN, DATA_OUT;
  logic       ACKN, DATA_VALID, BUSY, ERR;
  logic [1:0] WORD_NUM;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sbus_mem_ctl dut (
    .mboxClk(clk), .CROBAR(CROBAR), .START(START), .ADR(ADR), .RQ(RQ),
    .RD_RQ(RD_RQ), .WR_RQ(WR_RQ), .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID),
    .ACKN(ACKN), .DATA_VALID(DATA_VALID), .DATA_OUT(DATA_OUT), .WORD_NUM(WORD_NUM),
    .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct packed {
    pAdr_t            adr;
    logic [3:0]       rq;
    logic [2:0]       n;
    logic [3:0][1:0]  idx;
    logic [3:0][35:0] dat;
    logic [7:0]       poke;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rd_vec_t mk(input pAdr_t a, input logic [3:0] rq, input int n,
                                 input logic [1:0] i0, i1, i2, i3,
                                 input word_t d0, d1, d2, d3, input int poke);
    rd_vec_t r;
    r.adr = a; r.rq = rq; r.n = 3'(n); r.poke = 8'(poke);
    r.idx[0] = i0; r.idx[1] = i1; r.idx[2] = i2; r.idx[3] = i3;
    r.dat[0] = d0; r.dat[1] = d1; r.dat[2] = d2; r.dat[3] = d3;
    return r;
  endfunction

  task automatic run_rd(input rd_vec_t v, input int tag);
    int acks = 0, dvs = 0, drop = -1;
    RD_RQ = 1'b1; WR_RQ = 1'b0; ADR = v.adr; RQ = v.rq; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ACKN) begin
        acks++;
        chk($sformatf("r%0d_ackn_cycle", tag), 64'(c), 64'd2);
      end
      if (DATA_VALID) begin
        if (dvs < int'(v.n)) begin
          chk($sformatf("r%0d_dv_cycle", tag), 64'(c), 64'(5 + dvs));
          chk($sformatf("r%0d_word_num", tag), 64'(WORD_NUM), 64'(v.idx[dvs]));
          chk($sformatf("r%0d_data", tag), 64'(DATA_OUT), 64'(v.dat[dvs]));
        end
        dvs++;
      end
      if (!BUSY && drop < 0) drop = c;
      START = (c == int'(v.poke));
      tick();
    end
    START = 1'b0;
    chk($sformatf("r%0d_ackn_count", tag), 64'(acks), 64'd1);
    chk($sformatf("r%0d_dv_count", tag), 64'(dvs), 64'(v.n));
    chk($sformatf("r%0d_busy_drop", tag), 64'(drop), (v.n == 0) ? 64'd3 : 64'(5 + int'(v.n)));
  endtask

  task automatic run_wr(input pAdr_t a, input logic [3:0] rq, input logic [3:0][35:0] d,
                        input int beats, input string name);
    RD_RQ = 1'b0; WR_RQ = 1'b1; ADR = a; RQ = rq; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 10 && !ACKN; k++) tick();
    chk({name, "_ackn"}, 64'(ACKN), 64'd1);
    tick();
    for (int b = 0; b < beats; b++) begin
      DATA_IN = d[b]; DATA_IN_VALID = 1'b1;
      tick();
    end
    DATA_IN_VALID = 1'b0;
    for (int k = 0; k < 30 && BUSY; k++) tick();
    chk({name, "_done"}, 64'(BUSY), 64'd0);
  endtask

  task automatic reject(input logic rd, input logic wr, input pAdr_t a, input string name);
    RD_RQ = rd; WR_RQ = wr; ADR = a; RQ = 4'b1111; START = 1'b1;
    tick();
    START = 1'b0;
    chk({name, "_err"}, 64'(ERR), 64'd1);
    chk({name, "_ackn"}, 64'(ACKN), 64'd0);
    chk({name, "_busy"}, 64'(BUSY), 64'd0);
    tick();
    chk({name, "_err_clr"}, 64'(ERR), 64'd0);
    chk({name, "_ackn2"}, 64'(ACKN | BUSY), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0][35:0] wd;
    int bad;
    vecs[0] = mk(22'h101, 4'b1111, 4, 1, 2, 3, 0, 36'd2, 36'd3, 36'd4, 36'd1, 0);
    vecs[1] = mk(22'h102, 4'b0101, 2, 2, 0, 0, 0, 36'd3, 36'd1, 36'd0, 36'd0, 0);
    vecs[2] = mk(22'h103, 4'b1000, 1, 3, 0, 0, 0, 36'd4, 36'd0, 36'd0, 36'd0, 0);
    vecs[3] = mk(22'h200, 4'b1111, 4, 0, 1, 2, 3, 36'o111, 36'o222, 36'd7, 36'o777, 0);
    vecs[4] = mk(22'h100, 4'b0000, 0, 0, 0, 0, 0, 36'd0, 36'd0, 36'd0, 36'd0, 0);
    vecs[5] = mk(22'h100, 4'b1111, 4, 0, 1, 2, 3, 36'd1, 36'd2, 36'd3, 36'd4, 6);

    CROBAR = 1'b1; START = 1'b0; RD_RQ = 1'b0; WR_RQ = 1'b0; ADR = '0; RQ = '0;
    DATA_IN = '0; DATA_IN_VALID = 1'b0;
    repeat (3) tick();
    chk("rst_ackn", 64'(ACKN), 64'd0);
    chk("rst_dv", 64'(DATA_VALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    chk("rst_data", 64'(DATA_OUT), 64'd0);
    chk("rst_wn", 64'(WORD_NUM), 64'd0);
    CROBAR = 1'b0;
    tick();

    wd[0] = 36'd1; wd[1] = 36'd2; wd[2] = 36'd3; wd[3] = 36'd4;
    run_wr(22'h100, 4'b1111, wd, 4, "w100");
    wd[0] = 36'd5; wd[1] = 36'd6; wd[2] = 36'd7; wd[3] = 36'd8;
    run_wr(22'h200, 4'b1111, wd, 4, "w200");
    wd[0] = 36'hA0; wd[1] = 36'hA1; wd[2] = 36'hA2; wd[3] = 36'hA3;
    run_wr(22'h300, 4'b1111, wd, 4, "w300");
    // Sparse write: order 3,0,1; the extra fourth beat must be ignored.
    wd[0] = 36'o777; wd[1] = 36'o111; wd[2] = 36'o222; wd[3] = 36'o333;
    run_wr(22'h202, 4'b1011, wd, 4, "wsparse");

    for (int i = 0; i < 6; i++) run_rd(vecs[i], i);

    reject(1'b1, 1'b0, 22'd4096, "nxm");
    reject(1'b1, 1'b1, 22'h100, "both_op");
    reject(1'b0, 1'b0, 22'h100, "no_op");

    // Write timeout after a single beat.
    RD_RQ = 1'b0; WR_RQ = 1'b1; ADR = 22'h300; RQ = 4'b1111; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 10 && !ACKN; k++) tick();
    chk("to_ackn", 64'(ACKN), 64'd1);
    tick();
    DATA_IN = 36'o55; DATA_IN_VALID = 1'b1;
    tick();
    DATA_IN_VALID = 1'b0;
    repeat (15) tick();
    chk("to_err_early", 64'(ERR), 64'd0);
    chk("to_busy_held", 64'(BUSY), 64'd1);
    tick();
    chk("to_err", 64'(ERR), 64'd1);
    tick();
    chk("to_err_clr", 64'(ERR), 64'd0);
    chk("to_busy_clr", 64'(BUSY), 64'd0);
    run_rd(mk(22'h300, 4'b1111, 4, 0, 1, 2, 3, 36'o55, 36'hA1, 36'hA2, 36'hA3, 0), 10);

    // Reset during the second read beat.
    RD_RQ = 1'b1; WR_RQ = 1'b0; ADR = 22'h100; RQ = 4'b1111; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk("cb_dv1", 64'(DATA_VALID), 64'd1);
    tick();
    chk("cb_dv2", 64'(DATA_VALID), 64'd1);
    chk("cb_wn2", 64'(WORD_NUM), 64'd1);
    CROBAR = 1'b1;
    tick();
    chk("cb_outs", 64'({ACKN, DATA_VALID, BUSY, ERR, WORD_NUM}), 64'd0);
    chk("cb_data", 64'(DATA_OUT), 64'd0);
    CROBAR = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      if (DATA_VALID || BUSY || ERR || ACKN) bad++;
    end
    chk("cb_quiet", 64'(bad), 64'd0);
    run_rd(vecs[5], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
